// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, single-cycle synchronous imem access,
// and a 2-entry {pc, instr} skid buffer toward OF with branch-redirect flush.
package if_stage_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } If_Of_t;
endpackage

module if_stage
  import if_stage_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic [31:0] Imem_Data,
  input  logic        Br_Taken,
  input  logic [31:0] Br_Target,
  output If_Of_t      If_Payld_o,
  output logic        If_Valid_o,
  input  logic        If_Ready_i
);
  typedef enum logic [1:0] {IDLE, RUN, REDIR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, inflight_pc;
  logic        inflight;
  If_Of_t      fifo_q [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        pop, push, issue;
  logic [2:0]  occ;

  assign If_Valid_o = (count != 2'd0) && !Br_Taken;
  assign pop        = If_Valid_o && If_Ready_i;
  // A response landing in REDIR was fetched on the old path
  assign push       = inflight && (state != REDIR);
  assign occ        = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue      = (state == RUN) && Start && !Br_Taken && (occ < 3'd2);
  assign Imem_Req   = issue;
  assign Imem_Addr  = pc;
  assign If_Payld_o = (count != 2'd0) ? fifo_q[rd_ptr] : '0;

  always_comb begin
    state_nxt = state;
    if (Br_Taken) state_nxt = REDIR;
    else begin
      unique case (state)
        IDLE:    if (Start) state_nxt = RUN;
        RUN:     if (!Start) state_nxt = IDLE;
        REDIR:   state_nxt = Start ? RUN : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      pc          <= 32'h0;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else begin
      state       <= state_nxt;
      inflight    <= issue;
      inflight_pc <= pc;
      if (Br_Taken)   pc <= {Br_Target[31:2], 2'b00};
      else if (issue) pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else if (Br_Taken) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{pc: inflight_pc, instr: Imem_Data};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based behavioural model.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam int M_IDLE = 0, M_RUN = 1, M_REDIR = 2;

  logic        Clk = 1'b0, Rst = 1'b0, Start = 1'b0;
  logic        Br_Taken = 1'b0, If_Ready_i = 1'b0;
  logic [31:0] Br_Target = 32'h0, Imem_Data = 32'h0;
  logic        Imem_Req, If_Valid_o;
  logic [31:0] Imem_Addr;
  If_Of_t      If_Payld_o;

  if_stage dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr), .Imem_Data(Imem_Data),
    .Br_Taken(Br_Taken), .Br_Target(Br_Target),
    .If_Payld_o(If_Payld_o), .If_Valid_o(If_Valid_o), .If_Ready_i(If_Ready_i)
  );

  always #5 Clk = ~Clk;

  // Synchronous memory; garbage on idle cycles so unrequested data is visible
  always @(posedge Clk) Imem_Data <= Imem_Req ? (Imem_Addr ^ K) : $urandom();

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [31:0] m_pc;
  int          m_mode;
  logic [63:0] m_q[$];
  bit          m_pend;
  logic [31:0] m_pend_pc;

  task automatic model_reset();
    m_pc = 32'h0; m_mode = M_IDLE; m_q.delete(); m_pend = 1'b0; m_pend_pc = 32'h0;
  endtask

  // Called at a negedge; returns at the next negedge
  task automatic step(input bit st, input bit rdy, input bit br, input logic [31:0] tgt);
    bit ev, er, tk;
    logic [63:0] ep;
    Start = st; If_Ready_i = rdy; Br_Taken = br; Br_Target = tgt;
    #1;
    ev = (m_q.size() != 0) && !br;
    ep = (m_q.size() != 0) ? m_q[0] : 64'h0;
    tk = ev && rdy;
    er = (m_mode == M_RUN) && st && !br && (m_q.size() + int'(m_pend) - int'(tk) < 2);
    chk("imem_req", 64'(Imem_Req), 64'(er));
    chk("imem_addr", 64'(Imem_Addr), 64'(m_pc));
    chk("if_valid", 64'(If_Valid_o), 64'(ev));
    chk("if_payld", If_Payld_o, ep);
    @(posedge Clk);
    if (tk) void'(m_q.pop_front());
    if (m_pend && m_mode != M_REDIR) m_q.push_back({m_pend_pc, m_pend_pc ^ K});
    if (br) m_q.delete();
    m_pend = er;
    m_pend_pc = m_pc;
    if (br) m_pc = {tgt[31:2], 2'b00};
    else if (er) m_pc = m_pc + 32'd4;
    if (br) m_mode = M_REDIR;
    else if (m_mode == M_IDLE) m_mode = st ? M_RUN : M_IDLE;
    else if (m_mode == M_RUN) m_mode = st ? M_RUN : M_IDLE;
    else m_mode = st ? M_RUN : M_IDLE;
    @(negedge Clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock
  task automatic pulse_reset(input int cyc);
    Br_Taken = 1'b0;
    Rst = 1'b0;
    #1;
    chk("rst_req", 64'(Imem_Req), 64'h0);
    chk("rst_addr", 64'(Imem_Addr), 64'h0);
    chk("rst_valid", 64'(If_Valid_o), 64'h0);
    chk("rst_payld", If_Payld_o, 64'h0);
    model_reset();
    repeat (cyc) @(negedge Clk);
    Rst = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge Clk);
    pulse_reset(2);
    // Cold start and streaming
    repeat (12) step(1, 1, 0, 0);
    // Back-pressure then release
    repeat (5) step(1, 0, 0, 0);
    repeat (6) step(1, 1, 0, 0);
    // Redirect with a full buffer and low-bit target
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 1, 32'h0000_0103);
    repeat (6) step(1, 1, 0, 0);
    // Redirect with a fetch in flight
    step(1, 0, 0, 0);
    step(1, 1, 1, 32'h0000_0103);
    repeat (5) step(1, 1, 0, 0);
    // Back-to-back redirects
    step(1, 1, 1, 32'h0000_0040);
    step(1, 1, 1, 32'h0000_0080);
    repeat (6) step(1, 1, 0, 0);
    // PC wrap
    step(1, 1, 1, 32'hFFFF_FFF8);
    repeat (6) step(1, 1, 0, 0);
    // Start dropped with a fetch in flight, then reset
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    pulse_reset(2);
    repeat (8) step(1, 1, 0, 0);
    // Start toggling while streaming
    repeat (2) step(0, 1, 0, 0);
    repeat (4) step(1, 1, 0, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset($urandom_range(1, 3));
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0, $urandom());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
